// File: rtl/vme_cmd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vme_cmd_arbiter_if                                                         |
// | Requester and VME command/data register signals of the command arbiter.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface vme_cmd_arbiter_if;
  logic        req0;
  logic        req1;
  logic        rw0;
  logic        rw1;
  logic [31:0] cmd0;
  logic [31:0] cmd1;
  logic [31:0] dat0;
  logic [31:0] dat1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] rdata;
  logic        err;
  logic        vme_cmd_rd;
  logic        start;
  logic [31:0] vme_cmd_reg;
  logic [31:0] vme_dat_reg_in;
  logic [31:0] vme_dat_reg_out;
  logic        vme_dat_wr;
  logic [7:0]  stray_cnt;

  modport slave (
    input  req0, req1, rw0, rw1, cmd0, cmd1, dat0, dat1,
    input  vme_cmd_rd, vme_dat_reg_out, vme_dat_wr,
    output gnt0, gnt1, done0, done1, rdata, err,
    output start, vme_cmd_reg, vme_dat_reg_in, stray_cnt
  );

  modport master (
    output req0, req1, rw0, rw1, cmd0, cmd1, dat0, dat1,
    output vme_cmd_rd, vme_dat_reg_out, vme_dat_wr,
    input  gnt0, gnt1, done0, done1, rdata, err,
    input  start, vme_cmd_reg, vme_dat_reg_in, stray_cnt
  );
endinterface
`default_nettype wire

// File: rtl/vme_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vme_cmd_arbiter                                                            |
// | Round-robin sharing of the VME command/data registers by two requesters.   |
// | Optional watchdog: define VME_ARB_TIMEOUT_EN.                              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module vme_cmd_arbiter #(
  parameter logic [31:0] MASK    = 32'h00a80000,
  parameter int          TIMEOUT = 256
) (
  input wire               clk,
  input wire               rst_n,
  vme_cmd_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [31:0] C_RD_BIT   = 32'h0200_0000;
  localparam logic [31:0] C_WR_BIT   = 32'h0100_0000;
  localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        start_q, start_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  stray_q, stray_d;
  logic        win;
  logic        win_rw;
  logic        finish;
`ifdef VME_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    start_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    cmd_d   = cmd_q;
    dat_d   = dat_q;
    stray_d = stray_q;
    win     = 1'b0;
    win_rw  = 1'b0;
    finish  = 1'b0;
`ifdef VME_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.vme_dat_wr && (stray_q != 8'hff)) begin
          stray_d = stray_q + 8'd1;
        end
        if (bus.vme_cmd_rd && (bus.req0 || bus.req1)) begin
          // On a tie the port not granted last wins; otherwise the lone requester.
          win     = (bus.req0 && bus.req1) ? ~ptr_q : bus.req1;
          win_rw  = win ? bus.rw1 : bus.rw0;
          ptr_d   = win;
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          start_d = 1'b1;
          cmd_d   = (win ? bus.cmd1 : bus.cmd0) | MASK | (win_rw ? C_RD_BIT : C_WR_BIT);
          dat_d   = win ? bus.dat1 : bus.dat0;
          state_d = ST_WAIT;
`ifdef VME_ARB_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end

      ST_WAIT: begin
        if (bus.vme_dat_wr) begin
          rdata_d = bus.vme_dat_reg_out[15:0];
          err_d   = 1'b0;
          finish  = 1'b1;
        end
`ifdef VME_ARB_TIMEOUT_EN
        else if (cnt_q == C_TMO_LAST) begin
          rdata_d = 16'h0000;
          err_d   = 1'b1;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
        if (finish) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          cmd_d   = MASK;
          dat_d   = 32'h0000_0000;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      start_q <= 1'b0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      cmd_q   <= MASK;
      dat_q   <= 32'h0000_0000;
      stray_q <= 8'h00;
`ifdef VME_ARB_TIMEOUT_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      start_q <= start_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      dat_q   <= dat_d;
      stray_q <= stray_d;
`ifdef VME_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt0           = gnt0_q;
  assign bus.gnt1           = gnt1_q;
  assign bus.done0          = done0_q;
  assign bus.done1          = done1_q;
  assign bus.start          = start_q;
  assign bus.rdata          = rdata_q;
  assign bus.err            = err_q;
  assign bus.vme_cmd_reg    = cmd_q;
  assign bus.vme_dat_reg_in = dat_q;
  assign bus.stray_cnt      = stray_q;

  // Only the low half of the response word is returned to requesters.
  logic unused_ok;
`ifdef VME_ARB_TIMEOUT_EN
  assign unused_ok = ^bus.vme_dat_reg_out[31:16];
`else
  assign unused_ok = ^{bus.vme_dat_reg_out[31:16], C_TMO_LAST};
`endif

endmodule
`default_nettype wire

// File: tb/tb_vme_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vme_cmd_arbiter                                                         |
// | Directed stimulus with queued expectations checked by a separate monitor.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_vme_cmd_arbiter;

  localparam logic [31:0] C_MASK = 32'h00a80000;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   cyc;
  int   last_start;

  typedef struct {
    int          port;
    logic [31:0] cmd;
    logic [31:0] dat;
    int          gap;
  } s_exp_t;

  typedef struct {
    int          port;
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } d_exp_t;

  s_exp_t s_q[$];
  d_exp_t d_q[$];

  vme_cmd_arbiter_if bus ();

  vme_cmd_arbiter #(
    .MASK    (C_MASK),
    .TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_s(input int port, input logic [31:0] cmd, input logic [31:0] dat, input int gap);
    s_exp_t e;
    e.port = port; e.cmd = cmd; e.dat = dat; e.gap = gap;
    s_q.push_back(e);
  endtask

  task automatic push_d(input int port, input logic [15:0] rdata, input logic err, input int lat);
    d_exp_t e;
    e.port = port; e.rdata = rdata; e.err = err; e.lat = lat;
    d_q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT presents start or done.
  always @(negedge clk) begin
    s_exp_t se;
    d_exp_t de;
    cyc++;
    if (rst_n) begin
      if (bus.start) begin
        if (s_q.size() == 0) begin
          chk("unexpected_start", 32'(bus.start), 32'd0);
        end else begin
          se = s_q.pop_front();
          chk("gnt_port", {30'd0, bus.gnt1, bus.gnt0}, (se.port == 1) ? 32'd2 : 32'd1);
          chk("vme_cmd_reg", bus.vme_cmd_reg, se.cmd);
          chk("vme_dat_reg_in", bus.vme_dat_reg_in, se.dat);
          if (se.gap > 0) chk("start_gap", 32'(cyc - last_start), 32'(se.gap));
        end
        last_start = cyc;
      end else if (bus.gnt0 || bus.gnt1) begin
        chk("gnt_without_start", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      end
      if (bus.done0 || bus.done1) begin
        if (d_q.size() == 0) begin
          chk("unexpected_done", {30'd0, bus.done1, bus.done0}, 32'd0);
        end else begin
          de = d_q.pop_front();
          chk("done_port", {30'd0, bus.done1, bus.done0}, (de.port == 1) ? 32'd2 : 32'd1);
          chk("rdata", 32'(bus.rdata), 32'(de.rdata));
          chk("err", 32'(bus.err), 32'(de.err));
          chk("done_latency", 32'(cyc - last_start), 32'(de.lat));
          chk("cmd_reg_idle", bus.vme_cmd_reg, C_MASK);
        end
      end
    end
  end

  task automatic wait_gnt(output int port);
    port = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        port = bus.gnt1 ? 1 : 0;
        break;
      end
    end
    if (port < 0) begin
      n_chk++; n_fail++;
      $display("FAIL gnt_wait: no grant within 20 cycles, expected one");
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done0 || bus.done1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL done_wait: no done within 40 cycles, expected one");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    n_chk = 0; n_fail = 0; cyc = 0; last_start = 0;
    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.rw0 = 0; bus.rw1 = 0;
    bus.cmd0 = '0; bus.cmd1 = '0; bus.dat0 = '0; bus.dat1 = '0;
    bus.vme_cmd_rd = 0; bus.vme_dat_reg_out = '0; bus.vme_dat_wr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk("rst_done", {30'd0, bus.done1, bus.done0}, 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_cmd_reg", bus.vme_cmd_reg, 32'h00a80000);
    chk("rst_dat_reg", bus.vme_dat_reg_in, 32'd0);
    chk("rst_stray", 32'(bus.stray_cnt), 32'd0);

    // Single write, response 3 cycles after start
    bus.req0 = 1; bus.rw0 = 0; bus.cmd0 = 32'h00004010; bus.dat0 = 32'h1234;
    bus.vme_cmd_rd = 1; bus.vme_dat_reg_out = 32'hffff0000;
    push_s(0, 32'h01a84010, 32'h00001234, 0);
    push_d(0, 16'h0000, 1'b0, 4);
    wait_gnt(p);
    bus.req0 = 0;
    repeat (3) @(negedge clk);
    bus.vme_dat_wr = 1;
    @(negedge clk);
    bus.vme_dat_wr = 0;
    wait_done();

    // Read on port 1
    bus.req1 = 1; bus.rw1 = 1; bus.cmd1 = 32'h00004000; bus.dat1 = 32'h55;
    bus.vme_dat_reg_out = 32'h0000beef;
    push_s(1, 32'h02a84000, 32'h00000055, 0);
    push_d(1, 16'hbeef, 1'b0, 2);
    wait_gnt(p);
    bus.req1 = 0;
    @(negedge clk);
    bus.vme_dat_wr = 1;
    @(negedge clk);
    bus.vme_dat_wr = 0;
    wait_done();

    // Fairness: both requesting, immediate responses
    bus.req0 = 1; bus.req1 = 1; bus.rw0 = 0; bus.rw1 = 0;
    bus.cmd0 = 32'h100; bus.cmd1 = 32'h200; bus.dat0 = 32'ha; bus.dat1 = 32'hb;
    push_s(0, 32'h01a80100, 32'ha, 0);
    push_s(1, 32'h01a80200, 32'hb, 2);
    push_s(0, 32'h01a80100, 32'ha, 2);
    push_s(1, 32'h01a80200, 32'hb, 2);
    push_d(0, 16'h1000, 1'b0, 1);
    push_d(1, 16'h1001, 1'b0, 1);
    push_d(0, 16'h1002, 1'b0, 1);
    push_d(1, 16'h1003, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(p);
      if (p == 1) bus.req1 = 0; else bus.req0 = 0;
      bus.vme_dat_reg_out = 32'h1000 + 32'(i);
      bus.vme_dat_wr = 1;
      @(negedge clk);
      bus.vme_dat_wr = 0;
      if (p == 1) bus.req1 = 1; else bus.req0 = 1;
    end
    bus.req0 = 0; bus.req1 = 0;

`ifdef VME_ARB_TIMEOUT_EN
    // Timeout with no response, then a response on the timeout cycle
    bus.req0 = 1; bus.rw0 = 1; bus.cmd0 = 32'h10; bus.dat0 = 32'h0;
    push_s(0, 32'h02a80010, 32'h0, 0);
    push_d(0, 16'h0000, 1'b1, 8);
    wait_gnt(p);
    bus.req0 = 0;
    wait_done();
    bus.req0 = 1; bus.rw0 = 0; bus.cmd0 = 32'h20; bus.dat0 = 32'h77;
    bus.vme_dat_reg_out = 32'h00005a5a;
    push_s(0, 32'h01a80020, 32'h77, 0);
    push_d(0, 16'h5a5a, 1'b0, 8);
    wait_gnt(p);
    bus.req0 = 0;
    repeat (7) @(negedge clk);
    bus.vme_dat_wr = 1;
    @(negedge clk);
    bus.vme_dat_wr = 0;
    wait_done();
`else
    // Without the watchdog a slow response is still accepted
    bus.req0 = 1; bus.rw0 = 0; bus.cmd0 = 32'h20; bus.dat0 = 32'h77;
    bus.vme_dat_reg_out = 32'h00005a5a;
    push_s(0, 32'h01a80020, 32'h77, 0);
    push_d(0, 16'h5a5a, 1'b0, 21);
    wait_gnt(p);
    bus.req0 = 0;
    repeat (20) @(negedge clk);
    bus.vme_dat_wr = 1;
    @(negedge clk);
    bus.vme_dat_wr = 0;
    wait_done();
`endif

    // Backpressure: no grant while the decoder is busy
    @(negedge clk);
    bus.vme_cmd_rd = 0;
    bus.req0 = 1; bus.rw0 = 0; bus.cmd0 = 32'h30; bus.dat0 = 32'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_gnt0", 32'(bus.gnt0), 32'd0);
      chk("bp_start", 32'(bus.start), 32'd0);
    end
    push_s(0, 32'h01a80030, 32'h99, 0);
    bus.vme_cmd_rd = 1;
    wait_gnt(p);
    bus.req0 = 0;

    // Asynchronous reset during WAIT aborts without a done pulse
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", 32'(bus.start), 32'd0);
    chk("arst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("arst_cmd_reg", bus.vme_cmd_reg, 32'h00a80000);
    chk("arst_dat_reg", bus.vme_dat_reg_in, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", {30'd0, bus.done1, bus.done0}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_arst_done", {30'd0, bus.done1, bus.done0}, 32'd0);

    // Stray response strobes in IDLE
    for (int i = 0; i < 3; i++) begin
      bus.vme_dat_wr = 1;
      @(negedge clk);
      bus.vme_dat_wr = 0;
      @(negedge clk);
    end
    chk("stray_3", 32'(bus.stray_cnt), 32'd3);
    bus.vme_dat_wr = 1;
    repeat (300) @(negedge clk);
    bus.vme_dat_wr = 0;
    @(negedge clk);
    chk("stray_sat", 32'(bus.stray_cnt), 32'd255);

    repeat (5) @(negedge clk);
    chk("start_queue_empty", 32'(s_q.size()), 32'd0);
    chk("done_queue_empty", 32'(d_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
